// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: op codes, FSM states, op-class helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Ops whose digits go through the adder and update the running carry.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/FA_str.sv
// Single-bit structural full adder, the cell of the digit ripple chain.
// Latency: combinational.
// Backpressure: none.
module FA_str (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/alu_digit.sv
// One DIGIT-wide ALU slice: ripple adder of FA_str cells plus bitwise AND/OR/XOR.
// Latency: combinational.
// Backpressure: none; the caller holds the carry between digits.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] sum;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    FA_str u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Carry into the top bit is only meaningful on the most significant digit.
  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

  // Pick the bitwise result for logic ops, the adder sum otherwise.
  always_comb begin
    y = sum;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Digit-serial integer ALU (ADD/SUB/AND/OR/XOR, optional SLT via MULTICYCLE_ALU_SLT_EN).
// Latency: WIDTH/DIGIT digit cycles plus one finish cycle from the accepting edge to done.
// Backpressure: start only sampled in IDLE; start while busy is dropped, no queueing.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, rsr;
  logic [2:0]       op_q;
  logic             cy_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic             accept, last_dig, sub_req;
  logic [DIGIT-1:0] dig_y;
  logic             dig_co, dig_cm;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v;

`ifdef MULTICYCLE_ALU_SLT_EN
  assign sub_req = (op == ALU_SUB) || (op == ALU_SLT);
`else
  assign sub_req = (op == ALU_SUB);
`endif

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (sa[DIGIT-1:0]),
    .b     (sb[DIGIT-1:0]),
    .ci    (cy_q),
    .op    (op_q),
    .y     (dig_y),
    .co    (dig_co),
    .c_msb (dig_cm)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: one RUN cycle per digit, then a single FINISH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers RUN and FINISH, so it drops in the done cycle.
  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && start;
    last_dig = (state == RUN) && (cnt == CW'(N - 1));
  end

  // Operand shift registers, carry flop, digit counter and MSB overflow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      rsr   <= '0;
      op_q  <= '0;
      cy_q  <= 1'b0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= sub_req ? ~b : b;
      op_q  <= op;
      cy_q  <= sub_req;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      rsr <= WIDTH'({dig_y, rsr} >> DIGIT);
      sa  <= sa >> DIGIT;
      sb  <= sb >> DIGIT;
      cnt <= cnt + CW'(1);
      if (is_arith(op_q)) cy_q <= dig_co;
      if (last_dig) ovf_q <= dig_cm ^ dig_co;
    end
  end

  // Final result/flag selection; unknown ops collapse to zero with clear flags.
  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    case (op_q)
      ALU_ADD, ALU_SUB: begin
        fin_res = rsr;
        fin_c   = cy_q;
        fin_v   = ovf_q;
      end
      ALU_AND, ALU_OR, ALU_XOR: fin_res = rsr;
`ifdef MULTICYCLE_ALU_SLT_EN
      ALU_SLT: fin_res = {{(WIDTH-1){1'b0}}, rsr[WIDTH-1] ^ ovf_q};
`endif
      default: fin_res = '0;
    endcase
  end

  // Output registers, loaded once per operation in FINISH with a one-cycle done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (state == FINISH) begin
      result   <= fin_res;
      zero     <= (fin_res == '0);
      carry    <= fin_c;
      overflow <= fin_v;
      done     <= 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=8, DIGIT=4 with a model-fed scoreboard.
// Latency: expects done three cycles after the accepting edge.
// Backpressure: checks that start during busy is dropped.
module tb_multicycle_alu;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       busy, done, zero, carry, overflow;
  logic [7:0] result;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  multicycle_alu #(.WIDTH(8), .DIGIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one operation on 8-bit operands.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] s;
    e = '0;
    s = '0;
    case (o)
      3'b000: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[7:0];
        e.c = s[8];
        e.v = (x[7] == y[7]) && (e.r[7] != x[7]);
      end
      3'b001: begin
        s   = {1'b0, x} + {1'b0, ~y} + 9'd1;
        e.r = s[7:0];
        e.c = s[8];
        e.v = (x[7] != y[7]) && (e.r[7] != x[7]);
      end
      3'b010: e.r = x & y;
      3'b011: e.r = x | y;
      3'b100: e.r = x ^ y;
`ifdef MULTICYCLE_ALU_SLT_EN
      3'b101: e.r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
`endif
      default: e.r = 8'd0;
    endcase
    e.z = (e.r == 8'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request, push its expectation, drop start after the edge.
  task automatic drive_start(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, check its latency, then pop and compare the scoreboard entry.
  task automatic wait_check(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 10);
    chk({tag, ".latency"}, lat, exp_lat);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (done === 1'b1) begin
        chk({tag, ".result"},   result,   e.r);
        chk({tag, ".zero"},     zero,     e.z);
        chk({tag, ".carry"},    carry,    e.c);
        chk({tag, ".overflow"}, overflow, e.v);
        chk({tag, ".busy"},     busy,     1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saw_done;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.busy",     busy,     1'b0);
    chk("reset.done",     done,     1'b0);
    chk("reset.result",   result,   8'h00);
    chk("reset.zero",     zero,     1'b0);
    chk("reset.carry",    carry,    1'b0);
    chk("reset.overflow", overflow, 1'b0);

    // ADD with signed overflow; done must last exactly one cycle.
    drive_start(3'b000, 8'h7F, 8'h01);
    chk("add7f.busy", busy, 1'b1);
    wait_check("add7f", 3);
    @(negedge clk);
    chk("add7f.done_once", done, 1'b0);

    // ADD with carry out and zero result.
    drive_start(3'b000, 8'hFF, 8'h01);
    wait_check("addff", 3);
    @(negedge clk);

    // SUB equal operands: zero, no borrow.
    drive_start(3'b001, 8'h05, 8'h05);
    wait_check("sub55", 3);
    @(negedge clk);

    // SUB with borrow.
    drive_start(3'b001, 8'h03, 8'h05);
    wait_check("sub35", 3);
    @(negedge clk);

    // AND then XOR back-to-back, start held in the done cycle.
    drive_start(3'b010, 8'hF0, 8'h3C);
    wait_check("and", 3);
    drive_start(3'b100, 8'hAA, 8'hFF);
    chk("xor.busy", busy, 1'b1);
    wait_check("xor", 3);
    @(negedge clk);
    chk("xor.done_once", done, 1'b0);

    // OR for coverage of the remaining logic op.
    drive_start(3'b011, 8'h0C, 8'h50);
    wait_check("or", 3);
    @(negedge clk);

    // SLT: result depends on whether the feature is built in.
    drive_start(3'b101, 8'h80, 8'h01);
    wait_check("slt", 3);
    @(negedge clk);

    // Invalid op still completes with zero set.
    drive_start(3'b111, 8'h12, 8'h34);
    wait_check("inv", 3);
    @(negedge clk);

    // start while busy must be ignored; original result on schedule.
    drive_start(3'b000, 8'h11, 8'h22);
    start = 1'b1;
    op    = 3'b001;
    a     = 8'hFF;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_check("ignore", 2);
    @(negedge clk);
    chk("ignore.idle", busy, 1'b0);

    // Reset in the middle of RUN clears everything at once and produces no done.
    start = 1'b1;
    op    = 3'b000;
    a     = 8'h40;
    b     = 8'h40;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst.busy",     busy,     1'b0);
    chk("rst.done",     done,     1'b0);
    chk("rst.result",   result,   8'h00);
    chk("rst.zero",     zero,     1'b0);
    chk("rst.carry",    carry,    1'b0);
    chk("rst.overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    chk("rst.no_done", saw_done, 0);

    drive_start(3'b000, 8'h12, 8'h34);
    wait_check("post_rst_add", 3);
    @(negedge clk);
    chk("post_rst.sbq_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
